// File: rtl/multicycle_exu.sv
// Multi-cycle RV64I decode/execute unit: IDLE -> DECODE -> EXEC -> WB, halting on ebreak or illegal encodings.
// Define EXU_RTYPE_EN to add the register-register ALU group (opcode 0110011).
module multicycle_exu #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic            halt,
    output logic            halt_illegal,
    output logic [31:0]     halt_code,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int unsigned RAW = $clog2(NREG);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    } op_t;

    state_t          r_state;
    op_t             r_op;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_next_pc;
    logic [XLEN-1:0] r_regs [NREG];

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_legal;
    logic            w_use_rs2;
    logic            w_ebreak;
    op_t             w_op;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_next_pc;

    assign w_opcode  = r_inst[6:0];
    assign w_funct3  = r_inst[14:12];
    assign w_rd      = r_inst[11:7];
    assign w_ebreak  = (r_inst == 32'h0010_0073);
    assign w_imm_i   = {{(XLEN-12){r_inst[31]}}, r_inst[31:20]};
    assign w_imm_u   = {{(XLEN-32){r_inst[31]}}, r_inst[31:12], 12'b0};
    assign w_imm_j   = {{(XLEN-21){r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
    assign w_rs1_val = r_regs[RAW'(r_inst[19:15])];
    assign w_rs2_val = r_regs[RAW'(r_inst[24:20])];
    assign dbg_rdata = (32'(dbg_raddr) < NREG) ? r_regs[RAW'(dbg_raddr)] : '0;

    // Classify the latched instruction and pick its immediate.
    always_comb begin
        w_op      = OP_ADD;
        w_legal   = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm     = w_imm_i;
        case (w_opcode)
            7'b0010011: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_op = OP_SLTU;
                    3'b100:  w_op = OP_XOR;
                    3'b110:  w_op = OP_OR;
                    3'b111:  w_op = OP_AND;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0110111: begin w_legal = 1'b1; w_op = OP_LUI;   w_imm = w_imm_u; end
            7'b0010111: begin w_legal = 1'b1; w_op = OP_AUIPC; w_imm = w_imm_u; end
            7'b1101111: begin w_legal = 1'b1; w_op = OP_JAL;   w_imm = w_imm_j; end
            7'b1100111: begin w_legal = (w_funct3 == 3'b000); w_op = OP_JALR; end
`ifdef EXU_RTYPE_EN
            7'b0110011: begin
                w_use_rs2 = 1'b1;
                if (r_inst[31:25] == 7'b0000000) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        3'b000:  w_op = OP_ADD;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b110:  w_op = OP_OR;
                        3'b111:  w_op = OP_AND;
                        default: w_legal = 1'b0;
                    endcase
                end else if (r_inst[31:25] == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_op    = OP_SUB;
                end
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Result and next PC from the operands captured in DECODE.
    always_comb begin
        w_next_pc = pc + XLEN'(4);
        case (r_op)
            OP_ADD:   w_result = r_rs1 + r_opb;
            OP_SUB:   w_result = r_rs1 - r_opb;
            OP_SLT:   w_result = XLEN'($signed(r_rs1) < $signed(r_opb));
            OP_SLTU:  w_result = XLEN'(r_rs1 < r_opb);
            OP_XOR:   w_result = r_rs1 ^ r_opb;
            OP_OR:    w_result = r_rs1 | r_opb;
            OP_AND:   w_result = r_rs1 & r_opb;
            OP_LUI:   w_result = r_opb;
            OP_AUIPC: w_result = pc + r_opb;
            OP_JAL: begin
                w_result  = pc + XLEN'(4);
                w_next_pc = pc + r_opb;
            end
            OP_JALR: begin
                w_result  = pc + XLEN'(4);
                w_next_pc = (r_rs1 + r_opb) & ~XLEN'(1);
            end
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_ADD;
            r_inst       <= '0;
            r_rs1        <= '0;
            r_opb        <= '0;
            r_next_pc    <= '0;
            pc           <= RESET_PC;
            inst_ready   <= 1'b1;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
            halt         <= 1'b0;
            halt_illegal <= 1'b0;
            halt_code    <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_valid && inst_ready) begin
                        r_inst     <= inst;
                        inst_ready <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_ebreak) begin
                        halt_code <= r_regs[10][31:0];
                        halt      <= 1'b1;
                        r_state   <= S_HALT;
                    end else if (!w_legal) begin
                        halt         <= 1'b1;
                        halt_illegal <= 1'b1;
                        r_state      <= S_HALT;
                    end else begin
                        r_op    <= w_op;
                        r_rs1   <= w_rs1_val;
                        r_opb   <= w_use_rs2 ? w_rs2_val : w_imm;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    commit_valid <= 1'b1;
                    commit_rd    <= w_rd;
                    commit_data  <= (w_rd != 5'd0) ? w_result : '0;
                    r_next_pc    <= w_next_pc;
                    r_state      <= S_WB;
                end
                S_WB: begin
                    // commit_data already carries the result and is zero only for rd==0.
                    if (w_rd != 5'd0) begin
                        r_regs[RAW'(w_rd)] <= commit_data;
                    end
                    commit_valid <= 1'b0;
                    commit_rd    <= '0;
                    commit_data  <= '0;
                    pc           <= r_next_pc;
                    inst_ready   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_exu.sv
// Self-checking bench for multicycle_exu: directed steps plus random legal instructions against an ISA-level model.
module tb_multicycle_exu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [63:0] commit_data;
    logic        halt;
    logic        halt_illegal;
    logic [31:0] halt_code;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_regs [32];
    logic [63:0] m_pc;

    multicycle_exu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .pc           (pc),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .halt         (halt),
        .halt_illegal (halt_illegal),
        .halt_code    (halt_code),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
        dbg_raddr = idx;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    // ISA-level reference: kind 0 = retires, 1 = ebreak, 2 = illegal.
    function automatic void model(input logic [31:0] ins, output int kind, output logic [4:0] rd,
                                  output logic [63:0] data, output logic [63:0] npc);
        longint      si;
        logic [63:0] imm_i, imm_u, imm_j, a, b;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        si = longint'(ins[31:20]);
        if (si >= 2048) si -= 4096;
        imm_i = si;
        si = longint'(ins[31:12]) * 4096;
        if (ins[31]) si -= 64'sh1_0000_0000;
        imm_u = si;
        si = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
           + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (si >= 1048576) si -= 2097152;
        imm_j = si;
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        kind = 0;
        rd   = ins[11:7];
        data = 64'd0;
        npc  = m_pc + 64'd4;
        if (ins == 32'h0010_0073) kind = 1;
        else begin
            case (opc)
                7'h13: case (f3)
                    3'd0: data = a + imm_i;
                    3'd2: data = (longint'(a) < longint'(imm_i)) ? 64'd1 : 64'd0;
                    3'd3: data = (a < imm_i) ? 64'd1 : 64'd0;
                    3'd4: data = a ^ imm_i;
                    3'd6: data = a | imm_i;
                    3'd7: data = a & imm_i;
                    default: kind = 2;
                endcase
                7'h37: data = imm_u;
                7'h17: data = m_pc + imm_u;
                7'h6f: begin data = m_pc + 64'd4; npc = m_pc + imm_j; end
                7'h67: begin
                    if (f3 != 3'd0) kind = 2;
                    else begin data = m_pc + 64'd4; npc = (a + imm_i) & ~64'd1; end
                end
`ifdef EXU_RTYPE_EN
                7'h33: begin
                    if (f7 == 7'h00) begin
                        case (f3)
                            3'd0: data = a + b;
                            3'd2: data = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
                            3'd3: data = (a < b) ? 64'd1 : 64'd0;
                            3'd4: data = a ^ b;
                            3'd6: data = a | b;
                            3'd7: data = a & b;
                            default: kind = 2;
                        endcase
                    end else if (f7 == 7'h20 && f3 == 3'd0) data = a - b;
                    else kind = 2;
                end
`endif
                default: kind = 2;
            endcase
        end
        if (rd == 5'd0) data = 64'd0;
    endfunction

    function automatic logic [31:0] rand_inst();
        int         k;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        rd  = 5'($urandom_range(31, 0));
        rs1 = 5'($urandom_range(31, 0));
        rs2 = 5'($urandom_range(31, 0));
`ifdef EXU_RTYPE_EN
        k = $urandom_range(11, 0);
`else
        k = $urandom_range(9, 0);
`endif
        case (k % 6)
            0: f3 = 3'd0;
            1: f3 = 3'd2;
            2: f3 = 3'd3;
            3: f3 = 3'd4;
            4: f3 = 3'd6;
            default: f3 = 3'd7;
        endcase
        if (k <= 5) return {12'($urandom), rs1, f3, rd, 7'h13};
        case (k)
            6:  return {20'($urandom), rd, 7'h37};
            7:  return {20'($urandom), rd, 7'h17};
            8:  return {20'($urandom), rd, 7'h6f};
            9:  return {12'($urandom), rs1, 3'd0, rd, 7'h67};
            10: return {7'h00, rs2, rs1, 3'($urandom_range(7, 0) | 2), rd, 7'h33};
            default: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_pc = RESET_PC;
    endtask

    task automatic do_reset();
        inst_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_pc", pc, RESET_PC);
        check("rst_ready", inst_ready, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_rd", commit_rd, 0);
        check("rst_commit_data", commit_data, 0);
        check("rst_halt", halt, 0);
        check("rst_halt_illegal", halt_illegal, 0);
        check("rst_halt_code", halt_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_inst(input logic [31:0] ins);
        int          kind, w;
        logic [4:0]  rd;
        logic [63:0] data, npc;
        w = 0;
        @(negedge clk);
        while (inst_ready !== 1'b1 && w < 8) begin @(negedge clk); w++; end
        if (inst_ready !== 1'b1) begin
            check("ready_timeout", inst_ready, 1);
            return;
        end
        model(ins, kind, rd, data, npc);
        inst_valid = 1'b1;
        inst       = ins;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        inst       = $urandom;
        check("busy_ready", inst_ready, 0);
        check("decode_commit", commit_valid, 0);
        @(posedge clk); #1;
        if (kind != 0) begin
            check("halt", halt, 1);
            check("halt_illegal", halt_illegal, 64'(kind == 2));
            if (kind == 1) check("halt_code", halt_code, 64'(m_regs[10][31:0]));
            check("halt_pc", pc, m_pc);
            check("halt_ready", inst_ready, 0);
            return;
        end
        check("exec_commit", commit_valid, 0);
        @(posedge clk); #1;
        check("wb_commit_valid", commit_valid, 1);
        check("wb_commit_rd", commit_rd, 64'(rd));
        check("wb_commit_data", commit_data, data);
        check("wb_halt", halt, 0);
        if (rd != 5'd0) m_regs[rd] = data;
        m_pc = npc;
        @(posedge clk); #1;
        check("post_commit_valid", commit_valid, 0);
        check("post_pc", pc, m_pc);
        check("post_ready", inst_ready, 1);
        chk_reg("post_rd", rd, m_regs[rd]);
    endtask

    logic [63:0] p;
    logic [4:0]  r;

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'd0;
        dbg_raddr  = 5'd0;
        do_reset();

        run_inst(32'hFFF0_0093);
        chk_reg("x1_minus1", 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("pc_after_addi", pc, RESET_PC + 64'd4);

        run_inst(32'h0050_0013);
        chk_reg("x0_zero", 5'd0, 64'd0);

        run_inst(32'h8000_0137);
        chk_reg("lui_x2", 5'd2, 64'hFFFF_FFFF_8000_0000);
        p = pc;
        run_inst(32'h0000_0197);
        chk_reg("auipc_x3", 5'd3, p);

        p = pc;
        run_inst(32'h0080_00EF);
        chk_reg("jal_link", 5'd1, p + 64'd4);
        check("jal_pc", pc, p + 64'd8);
        run_inst(32'h0000_80E7);
        check("jalr_pc", pc, p + 64'd4);
        chk_reg("jalr_link", 5'd1, p + 64'd12);

        for (int i = 0; i < 60; i++) begin
            run_inst(rand_inst());
            r = 5'($urandom_range(31, 0));
            chk_reg("rand_reg", r, m_regs[r]);
        end

        run_inst(32'h02A0_0513);
        run_inst(32'h0010_0073);
        check("ebreak_code_42", halt_code, 64'd42);
        p = pc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inst_valid = 1'b1;
            inst       = 32'h0010_0093;
            @(posedge clk); #1;
            check("halted_stays", halt, 1);
            check("halted_ready", inst_ready, 0);
            check("halted_no_commit", commit_valid, 0);
            check("halted_pc", pc, p);
        end
        inst_valid = 1'b0;
        chk_reg("halted_x1", 5'd1, m_regs[1]);
        chk_reg("halted_x10", 5'd10, 64'd42);

        do_reset();
        chk_reg("reset_x10", 5'd10, 64'd0);
        run_inst(32'h0000_0033);
`ifdef EXU_RTYPE_EN
        check("add_no_halt", halt, 0);
        check("add_pc", pc, RESET_PC + 64'd4);
`else
        check("add_halt", halt, 1);
        check("add_halt_illegal", halt_illegal, 1);
`endif
        do_reset();

        @(negedge clk);
        inst_valid = 1'b1;
        inst       = 32'h0070_0293;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_commit", commit_valid, 0);
        check("abort_pc", pc, RESET_PC);
        check("abort_ready", inst_ready, 1);
        chk_reg("abort_x5", 5'd5, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", commit_valid, 0);
        end
        chk_reg("abort_x5_after", 5'd5, 64'd0);
        check("abort_pc_after", pc, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_exu.md
Name: multicycle_exu

Overview:
Multi-cycle RV64I decode/execute unit for the NPC core, the successor to the single-cycle addi/ebreak decoder. It accepts one instruction per valid/ready handshake and decodes it with correctly sign-extended immediates. It executes the instruction against an internal parametrised register file, writes back, and advances its own PC. It halts on ebreak or on an unsupported encoding and reports the halt through status ports that the simulation harness polls.

Parameters:
XLEN, 64, datapath and register width
NREG, 32, register count; x0 is hardwired to zero
RESET_PC, 64'h8000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  instruction is offered
inst_ready  out  1  unit can accept an instruction
inst  in  32  instruction word, sampled on handshake
pc  out  XLEN  PC of the current or next instruction
commit_valid  out  1  one-cycle pulse on retire
commit_rd  out  5  destination register of the retired instruction (0 if none)
commit_data  out  XLEN  value written to rd
halt  out  1  sticky; unit has stopped
halt_illegal  out  1  sticky; the halt was caused by an unsupported instruction
halt_code  out  32  a0[31:0], sampled at ebreak
dbg_raddr  in  5  testbench register read address
dbg_rdata  out  XLEN  combinational read of dbg_raddr; x0 reads as 0

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - On reset: state=IDLE, pc=RESET_PC, all registers 0, inst_ready=1, commit_valid=0, commit_rd=0, commit_data=0, halt=0, halt_illegal=0, halt_code=0.
  - Reset asserted mid-instruction aborts it: no writeback and no commit.
- FSM states: IDLE, DECODE, EXEC, WB, HALT.
- IDLE:
  - inst_ready=1.
  - On inst_valid && inst_ready: latch inst and go to DECODE.
  - With no handshake, remain in IDLE.
- DECODE:
  - Read rs1 and rs2, build imm, classify the instruction.
  - EBREAK (32'h0010_0073): halt_code=x10[31:0], go to HALT.
  - Unsupported opcode or funct3: halt_illegal=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - Compute result and next_pc.
  - Supported instructions: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, LUI, AUIPC, JAL, JALR.
  - Immediates: I, U and J formats are sign-extended to XLEN. U-format is {inst[31:12], 12'b0} sign-extended. J-format is {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Arithmetic is modulo 2^XLEN.
  - SLTI compares signed; SLTIU compares unsigned against the sign-extended immediate.
  - LUI result = imm. AUIPC result = pc + imm.
  - JAL/JALR result = pc + 4. JAL next_pc = pc + imm. JALR next_pc = (rs1 + imm) & ~1, using rs1 read before the writeback, so rd==rs1 is safe.
  - All other instructions: next_pc = pc + 4.
- WB:
  - Write result to rd only if rd != 0.
  - commit_valid=1 for exactly this cycle, with commit_rd=rd and commit_data=result. commit_data=0 when rd=0.
  - pc <= next_pc; go to IDLE.
- Latency and throughput:
  - Handshake in cycle T gives commit_valid in cycle T+3.
  - Throughput is one instruction per 4 cycles.
  - inst_ready=0 in DECODE, EXEC, WB and HALT.
- HALT:
  - Terminal state: halt=1 and inst_ready=0.
  - pc holds the address of the halting instruction.
  - No further writes; leave only by reset.
- inst_valid while not ready is ignored; the instruction is not consumed.
- Register file writes occur only in WB. dbg_rdata reflects the write from the next cycle onward.

Optional Feature:
Macro EXU_RTYPE_EN.
- Defined: opcode 0110011 is decoded with register-register ADD, SUB (funct7=0100000), SLT, SLTU, XOR, OR and AND, using the same timing as the I-type instructions. Other funct7/funct3 combinations are illegal.
- Undefined: opcode 0110011 is illegal (halt_illegal=1).

Test Plan:
- Reset, then ADDI x1,x0,-1 (32'hFFF0_0093): commit at T+3 with rd=1 and data=64'hFFFF_FFFF_FFFF_FFFF; pc=RESET_PC+4.
- ADDI x0,x0,5: commit_rd=0 and commit_data=0; dbg_rdata for x0 reads 0.
- LUI x2,0x80000, then AUIPC x3,0: x2=64'hFFFF_FFFF_8000_0000; x3 equals the pc of the AUIPC.
- JAL x1,+8 at pc P: x1=P+4, pc=P+8. Then JALR x1,0(x1) with x1=P+4: pc=P+4, x1=P+12.
- ADDI x10,x0,42, then EBREAK: halt=1, halt_code=42, inst_ready stays 0, and further inst_valid has no effect. Reset clears everything.
- Offer 32'h0000_0033 (ADD): with EXU_RTYPE_EN, it commits; without it, halt=1 and halt_illegal=1. Separately, assert reset during EXEC: no commit, and pc=RESET_PC.
